uart_tx_fifo: RTL and testbench

//  Memory-mapped serial console transmitter driving ftdi_tx.
//  The CPU byte bus writes characters into a FIFO. The block serialises them as
//  8N1 frames, LSB first, with the line idling high.
//  The top-level address decoder gates the write strobe, in the same way the

---
 rtl/uart_tx_fifo.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// 8N1 serial console transmitter behind a 2**FIFO_AW byte FIFO; a write reaches tx two edges later.
// No backpressure: writes while full are dropped and set sticky ovf. Parity option: UART_TX_PARITY_EN.
module uart_tx_fifo #(
  parameter int CLK_HZ  = 25000000,
  parameter int BAUD    = 115200,
  parameter int FIFO_AW = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       wren,
  input  logic [7:0] data_in,
  input  logic       ovf_clr,
  output logic [7:0] status,
  output logic       tx
);

  localparam int DIV   = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int TW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [TW-1:0]    RELOAD   = TW'(DIV - 1);
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
  logic par;
`endif

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic [FIFO_AW:0]   count_nxt;
  logic               empty;
  logic               full;
  logic               ovf;
  logic               push;
  logic               pop;
  logic               bit_end;
  logic [2:0]         state;
  logic [2:0]         bit_idx;
  logic [TW-1:0]      timer;
  logic [7:0]         shift;
  logic [7:0]         head;

  assign head    = mem[rd_ptr];
  assign bit_end = (timer == '0);
  assign push    = wren && !full;
  // The last stop-bit clock doubles as the idle pop slot, so queued frames abut with one stop bit.
  assign pop     = !empty && ((state == IDLE) || ((state == STOP) && bit_end));
  assign status  = {4'b0000, ovf, (state != IDLE) || !empty, full, empty};

  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + 1'b1;
    end else if (pop && !push) begin
      count_nxt = count - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == FULL_CNT);
      if (wren && full) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      tx      <= 1'b1;
      timer   <= '0;
      bit_idx <= '0;
      shift   <= '0;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else if (pop) begin
      shift <= head;
      tx    <= 1'b0;
      timer <= RELOAD;
      state <= START;
`ifdef UART_TX_PARITY_EN
      par   <= ^head;
`endif
    end else begin
      timer <= bit_end ? RELOAD : timer - 1'b1;
      case (state)
        IDLE: begin
          tx <= 1'b1;
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_idx <= '0;
            tx      <= shift[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              tx    <= par;
`else
              state <= STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state <= STOP;
            tx    <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: a frame-level model predicts status and each frame's start and byte.
module tb_uart_tx_fifo;
  localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * DIV;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       wren = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       ovf_clr = 1'b0;
  logic [7:0] status;
  logic       tx;

  uart_tx_fifo #(.CLK_HZ(1000), .BAUD(100), .FIFO_AW(4)) dut (
    .clock(clock), .reset_n(reset_n), .wren(wren), .data_in(data_in),
    .ovf_clr(ovf_clr), .status(status), .tx(tx)
  );

  always #5 clock = ~clock;

  typedef struct { logic [7:0] b; int t; } frm_t;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         next_free = 0;
  logic       m_ovf = 1'b0;
  logic       chk_on = 1'b0;
  logic [7:0] mq[$];
  frm_t       exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [7:0] exp_status();
    logic busy;
    busy = (cyc < next_free) || (mq.size() != 0);
    return {4'b0000, m_ovf, busy, mq.size() == 16, mq.size() == 0};
  endfunction

  function automatic logic exp_bit(input logic [7:0] b, input int bi);
    if (bi == 0) return 1'b0;
    if (bi <= 8) return b[bi-1];
    if (bi == 9 && NBITS == 11) return ^b;
    return 1'b1;
  endfunction

  // Reference model: a frame occupies the line for FRAME clocks from the edge it is popped.
  always @(posedge clock) begin
    frm_t f;
    logic full_now;
    cyc++;
    if (reset_n) begin
      full_now = (mq.size() == 16);
      if (mq.size() != 0 && cyc >= next_free) begin
        f.b = mq.pop_front();
        f.t = cyc;
        exp_q.push_back(f);
        next_free = cyc + FRAME;
      end
      if (ovf_clr) m_ovf = 1'b0;
      if (wren) begin
        if (full_now) m_ovf = 1'b1;
        else mq.push_back(data_in);
      end
    end
  end

  always @(negedge reset_n) begin
    mq.delete();
    exp_q.delete();
    next_free = 0;
    m_ovf = 1'b0;
  end

  logic       active = 1'b0;
  logic       have = 1'b0;
  logic       line_ok = 1'b1;
  logic [7:0] rx = 8'h00;
  int         st = 0;
  frm_t       cur;

  // Line monitor: decodes frames at mid-bit and checks every clock of each frame.
  always @(negedge clock) begin
    int d;
    int bi;
    if (chk_on) chk("status", {24'b0, status}, {24'b0, exp_status()});
    if (!reset_n) begin
      active = 1'b0;
    end else if (!active) begin
      if (tx == 1'b0) begin
        active = 1'b1;
        st = cyc;
        rx = 8'h00;
        line_ok = 1'b1;
        if (exp_q.size() == 0) begin
          have = 1'b0;
          total++;
          bad++;
          $display("FAIL unexpected_frame: start at cycle %0d, none expected", cyc);
        end else begin
          cur = exp_q.pop_front();
          have = 1'b1;
          chk("frame_start", cur.t == st ? 32'd1 : 32'(st), 32'd1);
        end
      end
    end else begin
      d = cyc - st;
      bi = d / DIV;
      if ((d % DIV) == DIV / 2 && bi >= 1 && bi <= 8) rx[bi-1] = tx;
      if (have && tx !== exp_bit(cur.b, bi)) line_ok = 1'b0;
      if (d == FRAME - 1) begin
        active = 1'b0;
        if (have) begin
          chk("rx_byte", {24'b0, rx}, {24'b0, cur.b});
          chk("line_shape", {31'b0, line_ok}, 32'd1);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [7:0] b);
    wren = 1'b1;
    data_in = b;
    step();
    wren = 1'b0;
  endtask

  task automatic wait_until(input int target);
    int n = 0;
    while (cyc < target && n < 5000) begin
      step();
      n++;
    end
    chk("wait_until", 32'(cyc), 32'(target));
  endtask

  task automatic drain();
    int n = 0;
    while ((mq.size() != 0 || cyc < next_free + 2 || active) && n < 5000) begin
      step();
      n++;
    end
    chk("drain_timeout", {31'b0, n >= 5000}, 32'd0);
  endtask

  initial begin
    int s;
    int lows;
    int prob;
    #2 reset_n = 1'b0;
    #1 chk_on = 1'b1;
    chk("reset_tx", {31'b0, tx}, 32'd1);
    chk("reset_status", {24'b0, status}, 32'h01);
    step(); step();
    reset_n = 1'b1;
    step(); step();

    // Single 0x55: latency, per-bit pattern and busy release.
    wren = 1'b1;
    data_in = 8'h55;
    step();
    wren = 1'b0;
    chk("t1_tx_k1", {31'b0, tx}, 32'd1);
    step();
    chk("t1_tx_k2", {31'b0, tx}, 32'd0);
    s = cyc;
    wait_until(s + FRAME - 1);
    chk("t1_busy_last", {31'b0, status[2]}, 32'd1);
    step();
    chk("t1_busy_drop", {31'b0, status[2]}, 32'd0);
    drain();

    // Back-to-back "ABC".
    wr(8'h41); wr(8'h42); wr(8'h43);
    drain();

    // Fill to full with a frame in flight, then overflow.
    for (int i = 0; i < 17; i++) wr(8'($urandom));
    chk("t3_full", {31'b0, status[1]}, 32'd1);
    wr(8'hEE);
    chk("t3_ovf_set", {31'b0, status[3]}, 32'd1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("t3_ovf_clr", {31'b0, status[3]}, 32'd0);

    // Write on the pop edge with 16 queued: dropped.
    wait_until(next_free - 1);
    wr(8'h99);
    chk("t4_ovf_popedge", {31'b0, status[3]}, 32'd1);
    chk("t4_not_full", {31'b0, status[1]}, 32'd0);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    drain();

    // Write on the pop edge with 3 queued: count unchanged.
    for (int i = 0; i < 4; i++) wr(8'($urandom));
    wait_until(next_free - 1);
    wr(8'h5A);
    chk("t4_cnt3_ovf", {31'b0, status[3]}, 32'd0);
    drain();

    // Reset 35 clocks into a frame with 4 queued.
    for (int i = 0; i < 5; i++) wr(8'($urandom));
    wait_until(next_free - FRAME + 35);
    reset_n = 1'b0;
    #1;
    chk("t5_tx_high", {31'b0, tx}, 32'd1);
    chk("t5_status", {24'b0, status}, 32'h01);
    step(); step(); step();
    reset_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (tx == 1'b0) lows++;
    end
    chk("t5_no_frames", 32'(lows), 32'd0);

    // 0x07: parity 1 when enabled, frame length from NBITS.
    wr(8'h07);
    s = cyc + 1;
    wait_until(s + FRAME - 1);
    chk("t6_busy_end", {31'b0, status[2]}, 32'd1);
    step();
    chk("t6_idle_after", {31'b0, status[2]}, 32'd0);
    drain();

    // Random traffic with varying write density and random ovf_clr pulses.
    for (int blk = 0; blk < 6; blk++) begin
      prob = (blk % 3 == 0) ? 100 : ((blk % 3 == 1) ? 20 : 2);
      for (int i = 0; i < 500; i++) begin
        wren = ($urandom_range(0, prob - 1) == 0);
        data_in = 8'($urandom);
        ovf_clr = ($urandom_range(0, 99) == 0);
        step();
      end
    end
    wren = 1'b0;
    ovf_clr = 1'b0;
    drain();
    chk("final_exp_empty", 32'(exp_q.size()), 32'd0);
    chk("final_tx_idle", {31'b0, tx}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
